// File: rtl/line_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// line_port_arbiter_if
//   Bundles the three requester channels (I-cache read, D-cache read, EWB
//   drain) and the shared cacheline-wide memory port into one interface.
//
//   Signals:
//     ic_read_i/ic_addr_i/ic_rdata_o/ic_resp_o      I-cache line read channel
//     dc_read_i/dc_addr_i/dc_rdata_o/dc_resp_o      D-cache line read channel
//     ewb_write_i/ewb_addr_i/ewb_wdata_i/ewb_resp_o eviction write buffer drain
//     mem_read_o/mem_write_o/mem_addr_o/mem_wdata_o memory request
//     mem_rdata_i/mem_resp_i                        memory response
//
//   Modports:
//     master  the arbiter: owns the memory request and the requester resps
//     slave   the surroundings: caches, EWB and the lower memory level
// ----------------------------------------------------------------------------
interface line_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              ic_read_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic [LINE_W-1:0] ic_rdata_o;
    logic              ic_resp_o;

    logic              dc_read_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [LINE_W-1:0] dc_rdata_o;
    logic              dc_resp_o;

    logic              ewb_write_i;
    logic [ADDR_W-1:0] ewb_addr_i;
    logic [LINE_W-1:0] ewb_wdata_i;
    logic              ewb_resp_o;

    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              mem_resp_i;

    modport master (
        input  ic_read_i, ic_addr_i,
        input  dc_read_i, dc_addr_i,
        input  ewb_write_i, ewb_addr_i, ewb_wdata_i,
        input  mem_rdata_i, mem_resp_i,
        output ic_rdata_o, ic_resp_o,
        output dc_rdata_o, dc_resp_o,
        output ewb_resp_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output ic_read_i, ic_addr_i,
        output dc_read_i, dc_addr_i,
        output ewb_write_i, ewb_addr_i, ewb_wdata_i,
        output mem_rdata_i, mem_resp_i,
        input  ic_rdata_o, ic_resp_o,
        input  dc_rdata_o, dc_resp_o,
        input  ewb_resp_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/line_port_arbiter.sv
// ----------------------------------------------------------------------------
// line_port_arbiter
//   Shares one cacheline-wide memory port between I-cache reads, D-cache
//   reads and eviction write buffer drains, one transaction at a time.
//   Reads win for latency and alternate between the caches; the EWB is
//   drained first when it holds the line a D-cache read wants, and is forced
//   through after STARVE_MAX read grants made while it was waiting.
//
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset; abandons any in-flight transaction
//     bus   line_port_arbiter_if.master (requester channels + memory port)
// ----------------------------------------------------------------------------
module line_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    line_port_arbiter_if.master  bus
);
    localparam int OFF   = $clog2(LINE_W / 8);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, IC_RD, DC_RD, EWB_WR} state_t;

    state_t           state;
    state_t           next_state;
    logic             rr_ptr;
    logic [CNT_W-1:0] starve_cnt;

    logic hazard;
    logic starve_full;
    logic grant_ic;
    logic grant_dc;
    logic grant_ewb;

    // A D-cache read of the line the EWB still holds must see the drained data.
    assign hazard = bus.dc_read_i && bus.ewb_write_i &&
                    (bus.dc_addr_i[ADDR_W-1:OFF] == bus.ewb_addr_i[ADDR_W-1:OFF]);
    assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));

    // Grants are only ever made on the IDLE -> busy transition.
    assign grant_ic  = (state == IDLE) && (next_state == IC_RD);
    assign grant_dc  = (state == IDLE) && (next_state == DC_RD);
    assign grant_ewb = (state == IDLE) && (next_state == EWB_WR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: arbitrate in IDLE, otherwise wait for the memory response.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (hazard) begin
                    next_state = EWB_WR;
                end else if (bus.ewb_write_i && starve_full) begin
                    next_state = EWB_WR;
                end else if (bus.ic_read_i && bus.dc_read_i) begin
                    next_state = rr_ptr ? DC_RD : IC_RD;
                end else if (bus.ic_read_i) begin
                    next_state = IC_RD;
                end else if (bus.dc_read_i) begin
                    next_state = DC_RD;
                end else if (bus.ewb_write_i) begin
                    next_state = EWB_WR;
                end
            end
            IC_RD, DC_RD, EWB_WR: begin
                if (bus.mem_resp_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Fairness bookkeeping: the round-robin pointer favours whichever cache
    // was not served last; the starvation counter tracks read grants that
    // bypassed a waiting EWB and saturates so the force condition holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (grant_ic) begin
                rr_ptr <= 1'b1;
            end else if (grant_dc) begin
                rr_ptr <= 1'b0;
            end

            if (grant_ewb) begin
                starve_cnt <= '0;
            end else if ((grant_ic || grant_dc) && bus.ewb_write_i && !starve_full) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // Moore memory request from the granted requester's live inputs with the
    // line offset cleared; resps are the memory response steered to the owner.
    always_comb begin
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.ic_resp_o   = 1'b0;
        bus.dc_resp_o   = 1'b0;
        bus.ewb_resp_o  = 1'b0;
        case (state)
            IC_RD: begin
                bus.mem_read_o = 1'b1;
                bus.mem_addr_o = {bus.ic_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
                bus.ic_resp_o  = bus.mem_resp_i;
            end
            DC_RD: begin
                bus.mem_read_o = 1'b1;
                bus.mem_addr_o = {bus.dc_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
                bus.dc_resp_o  = bus.mem_resp_i;
            end
            EWB_WR: begin
                bus.mem_write_o = 1'b1;
                bus.mem_addr_o  = {bus.ewb_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
                bus.mem_wdata_o = bus.ewb_wdata_i;
                bus.ewb_resp_o  = bus.mem_resp_i;
            end
            default: ;
        endcase
    end

    assign bus.ic_rdata_o = bus.mem_rdata_i;
    assign bus.dc_rdata_o = bus.mem_rdata_i;
endmodule

// File: tb/tb_line_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_line_port_arbiter
//   Directed bench for line_port_arbiter: single read latency, IC/DC
//   alternation, RAW hazard drain ordering, EWB starvation bound, reset
//   mid-transaction and stray memory responses in IDLE.
// ----------------------------------------------------------------------------
module tb_line_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int KIND_IC  = 0;
    localparam int KIND_DC  = 1;
    localparam int KIND_EWB = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    line_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    line_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edge active.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the stimulus.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance past the next active edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs,
                               input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ic_rd, input logic [ADDR_W-1:0] ic_a,
                                 input logic dc_rd, input logic [ADDR_W-1:0] dc_a,
                                 input logic ewb_wr, input logic [ADDR_W-1:0] ewb_a,
                                 input logic [LINE_W-1:0] ewb_d);
        bus.ic_read_i   = ic_rd;
        bus.ic_addr_i   = ic_a;
        bus.dc_read_i   = dc_rd;
        bus.dc_addr_i   = dc_a;
        bus.ewb_write_i = ewb_wr;
        bus.ewb_addr_i  = ewb_a;
        bus.ewb_wdata_i = ewb_d;
    endtask

    task automatic checkQuiet(input string tag);
        checkBit({tag, " mem_read"},  bus.mem_read_o,  1'b0);
        checkBit({tag, " mem_write"}, bus.mem_write_o, 1'b0);
        checkOutput({tag, " mem_addr"}, LINE_W'(bus.mem_addr_o), '0);
        checkOutput({tag, " mem_wdata"}, bus.mem_wdata_o, '0);
        checkBit({tag, " ic_resp"},  bus.ic_resp_o,  1'b0);
        checkBit({tag, " dc_resp"},  bus.dc_resp_o,  1'b0);
        checkBit({tag, " ewb_resp"}, bus.ewb_resp_o, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One grant with a single-cycle memory response, then the IDLE bubble.
    task automatic serveGrant(input string tag, input int kind,
                              input logic [ADDR_W-1:0] exp_addr);
        tick();
        checkBit({tag, " mem_read"},  bus.mem_read_o,  kind != KIND_EWB);
        checkBit({tag, " mem_write"}, bus.mem_write_o, kind == KIND_EWB);
        checkOutput({tag, " mem_addr"}, LINE_W'(bus.mem_addr_o), LINE_W'(exp_addr));
        bus.mem_resp_i = 1'b1;
        #1;
        checkBit({tag, " ic_resp"},  bus.ic_resp_o,  kind == KIND_IC);
        checkBit({tag, " dc_resp"},  bus.dc_resp_o,  kind == KIND_DC);
        checkBit({tag, " ewb_resp"}, bus.ewb_resp_o, kind == KIND_EWB);
        tick();
        bus.mem_resp_i = 1'b0;
        #1;
        checkBit({tag, " bubble read"},  bus.mem_read_o,  1'b0);
        checkBit({tag, " bubble write"}, bus.mem_write_o, 1'b0);
    endtask

    logic [LINE_W-1:0] pat_a;
    logic [LINE_W-1:0] pat_5;

    initial begin
        checks = 0;
        errors = 0;
        pat_a  = {8{32'hAAAA_AAAA}};
        pat_5  = {8{32'h5555_5555}};
        rst    = 1'b1;
        bus.mem_resp_i  = 1'b0;
        bus.mem_rdata_i = '0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

        // Reset state.
        tick();
        tick();
        checkQuiet("reset");
        rst = 1'b0;

        // Single IC read with a slow memory.
        applyStimulus(1'b1, 32'h0000_1234, 1'b0, '0, 1'b0, '0, '0);
        #1;
        checkBit("ic1 no read before grant", bus.mem_read_o, 1'b0);
        tick();
        checkBit("ic1 mem_read", bus.mem_read_o, 1'b1);
        checkBit("ic1 mem_write", bus.mem_write_o, 1'b0);
        checkOutput("ic1 mem_addr", LINE_W'(bus.mem_addr_o), LINE_W'(32'h0000_1220));
        tick();
        tick();
        checkBit("ic1 resp wait", bus.ic_resp_o, 1'b0);
        checkBit("ic1 read held", bus.mem_read_o, 1'b1);
        bus.mem_resp_i  = 1'b1;
        bus.mem_rdata_i = pat_a;
        #1;
        checkBit("ic1 ic_resp", bus.ic_resp_o, 1'b1);
        checkBit("ic1 dc_resp", bus.dc_resp_o, 1'b0);
        checkOutput("ic1 ic_rdata", bus.ic_rdata_o, pat_a);
        checkOutput("ic1 dc_rdata", bus.dc_rdata_o, pat_a);
        tick();
        bus.mem_resp_i = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        #1;
        checkBit("ic1 idle read", bus.mem_read_o, 1'b0);
        checkBit("ic1 idle resp", bus.ic_resp_o, 1'b0);

        // IC and DC held continuously from reset: strict alternation.
        doReset();
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, '0, '0);
        serveGrant("alt0 ic", KIND_IC, 32'h0000_0100);
        serveGrant("alt1 dc", KIND_DC, 32'h0000_0200);
        serveGrant("alt2 ic", KIND_IC, 32'h0000_0100);
        serveGrant("alt3 dc", KIND_DC, 32'h0000_0200);

        // RAW hazard: EWB drains the shared line first, then IC, then DC.
        doReset();
        applyStimulus(1'b1, 32'h0000_3000, 1'b1, 32'h0000_8040,
                      1'b1, 32'h0000_805C, pat_5);
        #1;
        tick();
        checkOutput("haz ewb wdata", bus.mem_wdata_o, pat_5);
        // Back up a cycle's worth of checks on the same grant via serveGrant
        // is not possible, so finish this grant by hand.
        checkBit("haz ewb mem_write", bus.mem_write_o, 1'b1);
        checkBit("haz ewb mem_read", bus.mem_read_o, 1'b0);
        checkOutput("haz ewb mem_addr", LINE_W'(bus.mem_addr_o), LINE_W'(32'h0000_8040));
        bus.mem_resp_i = 1'b1;
        #1;
        checkBit("haz ewb_resp", bus.ewb_resp_o, 1'b1);
        checkBit("haz dc_resp", bus.dc_resp_o, 1'b0);
        tick();
        bus.mem_resp_i  = 1'b0;
        bus.ewb_write_i = 1'b0;
        #1;
        checkBit("haz bubble write", bus.mem_write_o, 1'b0);
        serveGrant("haz ic", KIND_IC, 32'h0000_3000);
        bus.ic_read_i = 1'b0;
        serveGrant("haz dc", KIND_DC, 32'h0000_8040);
        bus.dc_read_i = 1'b0;

        // EWB starvation bound: four reads, forced drain, and again.
        doReset();
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200,
                      1'b1, 32'h0000_9000, pat_5);
        serveGrant("stv0 ic", KIND_IC, 32'h0000_0100);
        serveGrant("stv1 dc", KIND_DC, 32'h0000_0200);
        serveGrant("stv2 ic", KIND_IC, 32'h0000_0100);
        serveGrant("stv3 dc", KIND_DC, 32'h0000_0200);
        serveGrant("stv4 ewb", KIND_EWB, 32'h0000_9000);
        serveGrant("stv5 ic", KIND_IC, 32'h0000_0100);
        serveGrant("stv6 dc", KIND_DC, 32'h0000_0200);
        serveGrant("stv7 ic", KIND_IC, 32'h0000_0100);
        serveGrant("stv8 dc", KIND_DC, 32'h0000_0200);
        serveGrant("stv9 ewb", KIND_EWB, 32'h0000_9000);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);

        // Reset mid DC read: transaction abandoned, no resp ever issued.
        doReset();
        applyStimulus(1'b0, '0, 1'b1, 32'h0000_0400, 1'b0, '0, '0);
        tick();
        checkBit("rst dc granted", bus.mem_read_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dc_read_i = 1'b0;
        #1;
        checkQuiet("rst abandoned");
        bus.mem_resp_i = 1'b1;
        #1;
        checkQuiet("rst stray resp");
        tick();
        checkQuiet("rst stray resp next");

        // Idle with a spurious memory response and no requests.
        tick();
        checkQuiet("idle spurious a");
        tick();
        checkQuiet("idle spurious b");
        bus.mem_resp_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
